// File: rtl/proteus_pkg.sv
// proteus_pkg: shared width constants for the unpacker datapath
package proteus_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int BIT_IDX = 4;
  localparam int BUF_W = 2 * BIT_WIDTH;
  localparam int CNT_W = 6;
endpackage

// File: rtl/unpack_extract.sv
// unpack_extract: masks a w=n+1 bit field, extends it (sign when UNPACKER_SIGN_EXT_EN) and shifts it by offset
module unpack_extract #(
  parameter int BIT_WIDTH = proteus_pkg::BIT_WIDTH,
  parameter int BIT_IDX = proteus_pkg::BIT_IDX
) (
  input  logic [BIT_WIDTH-1:0] field_i,
  input  logic [BIT_IDX-1:0]   n_i,
  input  logic [BIT_IDX-1:0]   offset_i,
  output logic [BIT_WIDTH-1:0] value_o
);
  logic [BIT_WIDTH-1:0] mask, ext;
  // keep the low n+1 bits, fill the rest by extension, then restore fractional position
  always_comb begin
    mask = ~({BIT_WIDTH{1'b1}} << n_i << 1);
`ifdef UNPACKER_SIGN_EXT_EN
    ext = field_i[n_i] ? (field_i | ~mask) : (field_i & mask);
`else
    ext = field_i & mask;
`endif
    value_o = ext << offset_i;
  end
endmodule

// File: rtl/unpacker.sv
// unpacker: buffers LSB-first packed words and emits one expanded value per field (UNPACKER_SIGN_EXT_EN selects sign extension)
module unpacker #(
  parameter int BIT_WIDTH = proteus_pkg::BIT_WIDTH,
  parameter int BIT_IDX = proteus_pkg::BIT_IDX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cfg_load,
  input  logic [BIT_IDX-1:0]   i_n,
  input  logic [BIT_IDX-1:0]   i_offset,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  input  logic [BIT_WIDTH-1:0] i_in_data,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic [BIT_WIDTH-1:0] o_out_data,
  input  logic                 i_out_ready
);
  localparam int BW = proteus_pkg::BUF_W;
  localparam int CW = proteus_pkg::CNT_W;
  logic [BW-1:0] buf_q, buf_d, sh;
  logic [CW-1:0] cnt_q, cnt_d, cs, w;
  logic [BIT_IDX-1:0] n_q, n_d, off_q, off_d;
  logic ov_q, ov_d, acc, emit;
  logic [BIT_WIDTH-1:0] od_q, od_d, val;
  unpack_extract #(.BIT_WIDTH(BIT_WIDTH), .BIT_IDX(BIT_IDX)) u_ext (
    .field_i(buf_q[BIT_WIDTH-1:0]),
    .n_i(n_q),
    .offset_i(off_q),
    .value_o(val)
  );
  // handshakes, consume-then-append buffer update, config and flush override
  always_comb begin
    w = CW'(n_q) + CW'(1);
    o_in_ready = cnt_q <= CW'(BIT_WIDTH) && !i_cfg_load && !i_flush;
    acc = i_in_valid && o_in_ready;
    emit = !i_cfg_load && !i_flush && cnt_q >= w && (!ov_q || i_out_ready);
    sh = emit ? buf_q >> w : buf_q;
    cs = emit ? cnt_q - w : cnt_q;
    buf_d = (i_cfg_load || i_flush) ? '0 : acc ? (sh | (BW'(i_in_data) << cs)) : sh;
    cnt_d = (i_cfg_load || i_flush) ? '0 : acc ? cs + CW'(BIT_WIDTH) : cs;
    ov_d = !i_cfg_load && (emit || (ov_q && !i_out_ready));
    od_d = emit ? val : od_q;
    n_d = i_cfg_load ? i_n : n_q;
    off_d = i_cfg_load ? i_offset : off_q;
    o_out_valid = ov_q;
    o_out_data = od_q;
  end
  // state registers; reset restores full-width, zero-offset configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      n_q <= BIT_IDX'(BIT_WIDTH - 1);
      off_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      od_q <= od_d;
      n_q <= n_d;
      off_q <= off_d;
    end
  end
endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: directed self-checking bench for unpacker
module tb_unpacker;
  logic clk = 1'b0;
  logic rst, i_cfg_load, i_flush, i_in_valid, o_in_ready, o_out_valid, i_out_ready;
  logic [3:0] i_n, i_offset;
  logic [15:0] i_in_data, o_out_data;
  int n_chk = 0, n_fail = 0;
  bit acc;
  logic [15:0] got[$];
  always #5 clk = ~clk;
  unpacker dut (
    .clk(clk), .rst(rst), .i_cfg_load(i_cfg_load), .i_n(i_n), .i_offset(i_offset),
    .i_flush(i_flush), .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    acc = i_in_valid && o_in_ready;
    if (o_out_valid && i_out_ready) got.push_back(o_out_data);
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [3:0] n, input logic [3:0] off);
    i_cfg_load = 1'b1; i_n = n; i_offset = off;
    #1 chk("cfg_blocks_ready", o_in_ready, 1'b0);
    tick();
    i_cfg_load = 1'b0;
  endtask
  task automatic send(input logic [15:0] d);
    i_in_valid = 1'b1; i_in_data = d;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    chk("send_accepted", acc, 1'b1);
    i_in_valid = 1'b0;
  endtask
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic expect_q(input string tag, input logic [15:0] e[$]);
    chk({tag, "_count"}, got.size(), e.size());
    for (int k = 0; k < e.size(); k++) chk(tag, k < got.size() ? got[k] : 16'hxxxx, e[k]);
    got.delete();
  endtask
  initial begin
    rst = 1'b1; i_cfg_load = 0; i_flush = 0; i_in_valid = 0; i_in_data = 0;
    i_n = 0; i_offset = 0; i_out_ready = 1'b1;
    drain(2);
    rst = 1'b0;
    chk("reset_valid", o_out_valid, 1'b0);
    chk("reset_data", o_out_data, 16'h0);
    chk("reset_in_ready", o_in_ready, 1'b1);
    cfg(4'd15, 4'd0);
    send(16'h1234);
    chk("w16_latency_not_yet", o_out_valid, 1'b0);
    send(16'h8000);
    chk("w16_first_out", {o_out_valid, o_out_data}, {1'b1, 16'h1234});
    tick();
    chk("w16_second_out", {o_out_valid, o_out_data}, {1'b1, 16'h8000});
    drain(2);
    expect_q("w16_stream", '{16'h1234, 16'h8000});
    cfg(4'd3, 4'd0);
    send(16'hA3F1);
    drain(6);
`ifdef UNPACKER_SIGN_EXT_EN
    expect_q("w4_off0", '{16'h0001, 16'hFFFF, 16'h0003, 16'hFFFA});
`else
    expect_q("w4_off0", '{16'h0001, 16'h000F, 16'h0003, 16'h000A});
`endif
    cfg(4'd3, 4'd2);
    send(16'hA3F1);
    drain(6);
`ifdef UNPACKER_SIGN_EXT_EN
    expect_q("w4_off2", '{16'h0004, 16'hFFFC, 16'h000C, 16'hFFE8});
`else
    expect_q("w4_off2", '{16'h0004, 16'h003C, 16'h000C, 16'h0028});
`endif
    cfg(4'd4, 4'd0);
    send(16'hFFFF);
    send(16'h0001);
    drain(8);
`ifdef UNPACKER_SIGN_EXT_EN
    expect_q("w5_span", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h0000, 16'h0000});
`else
    expect_q("w5_span", '{16'h001F, 16'h001F, 16'h001F, 16'h0003, 16'h0000, 16'h0000});
`endif
    chk("w5_residual_held", o_out_valid, 1'b0);
    i_flush = 1'b1;
    #1 chk("flush_blocks_ready", o_in_ready, 1'b0);
    tick();
    i_flush = 1'b0;
    send(16'h0005);
    drain(6);
    expect_q("w5_after_flush", '{16'h0005, 16'h0000, 16'h0000});
    cfg(4'd3, 4'd0);
    i_out_ready = 1'b0;
    send(16'h4321);
    send(16'h8765);
    i_in_valid = 1'b1; i_in_data = 16'hCBA9;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold", {o_out_valid, o_out_data, o_in_ready}, {1'b1, 16'h0001, 1'b0});
    end
    i_out_ready = 1'b1;
    send(16'hCBA9);
    drain(16);
`ifdef UNPACKER_SIGN_EXT_EN
    expect_q("stall_stream", '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'hFFF8,
                               16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC});
`else
    expect_q("stall_stream", '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8,
                               16'h9, 16'hA, 16'hB, 16'hC});
`endif
    cfg(4'd15, 4'd0);
    i_out_ready = 1'b0;
    send(16'h0F0F);
    send(16'h0001);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_keeps_output", {o_out_valid, o_out_data}, {1'b1, 16'h0F0F});
    i_out_ready = 1'b1;
    drain(4);
    expect_q("flush_drops_residual", '{16'h0F0F});
    cfg(4'd11, 4'd0);
    i_out_ready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    chk("pre_reset_state", {o_out_valid, o_in_ready}, {1'b1, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_clear", {o_out_valid, o_out_data, o_in_ready}, {1'b0, 16'h0, 1'b1});
    i_out_ready = 1'b1;
    got.delete();
    send(16'hBEEF);
    drain(4);
    expect_q("post_reset_w16", '{16'hBEEF});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
